inst_fetch_unit: RTL and testbench
==================================

// Module: inst_fetch_unit
// PURPOSE
//  Instruction fetch stage directly upstream of the single-cycle core. It replaces the DPI
//  instruction lookup with a valid/ready memory request/response pair.
//  Holds the current fetch PC and presents one instruction plus its PC to the core.
//  Takes the core's computed dnpc as the next fetch address when the core accepts the instruction.
//  Flags bus errors, response timeouts and misaligned next-PC values.
// PARAMETERS
//  RESET_PC  32'h8000_0000  first fetch address after reset
//  TIMEOUT   16'd1024       max WAIT cycles without a response; 0 disables the timeout
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   asynchronous, active-low reset (0 = reset)
//  req_valid   out  1   memory read request valid
//  req_ready   in   1   memory accepts request
//  req_addr    out  32  word-aligned fetch address
//  rsp_valid   in   1   memory read data valid (single-cycle pulse)
//  rsp_data    in   32  instruction word
//  rsp_err     in   1   bus error; qualified by rsp_valid
//  inst_valid  out  1   instruction available to core
//  inst_ready  in   1   core consumes instruction this cycle
//  inst        out  32  instruction word
//  inst_pc     out  32  PC of inst
//  npc         in   32  core's dnpc; sampled only when inst_valid&inst_ready
//  err         out  1   sticky fault flag
//  err_cause   out  2   0 none, 1 bus error, 2 timeout, 3 misaligned npc
//  inst_count  out  32  number of instructions retired via inst handshake
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, fetch_pc=RESET_PC, all valids 0, inst=0, inst_pc=0,
//    err=0, err_cause=0, inst_count=0, wait_cnt=0.
//  - FSM states: IDLE, REQ, WAIT, HOLD, ERR. All outputs are decoded from registers; there are no
//    combinational paths from inputs to outputs.
//  - IDLE: no outputs asserted; goes to REQ unconditionally on the next cycle.
//  - REQ: req_valid=1, req_addr=fetch_pc. These are held stable until req_ready.
//    On req_valid&req_ready: go to WAIT and clear wait_cnt.
//  - WAIT: on rsp_valid&rsp_err -> ERR with cause 1. Error wins over data in the same cycle.
//    On rsp_valid&!rsp_err: inst<=rsp_data, inst_pc<=fetch_pc, go to HOLD.
//    Otherwise wait_cnt++. If TIMEOUT!=0 and wait_cnt==TIMEOUT-1 with no response -> ERR with cause 2.
//    A response in that same cycle is still accepted.
//  - HOLD: inst_valid=1; inst and inst_pc are held stable until inst_ready.
//    On inst_valid&inst_ready: inst_count++ (wraps at 2^32).
//    If npc[1:0]!=0: go to ERR with cause 3; fetch_pc is unchanged.
//    Otherwise fetch_pc<=npc and go to REQ.
//    Minimum of 3 cycles per instruction (REQ, WAIT, HOLD) when memory responds in 1 cycle.
//  - ERR: all valids are 0 and err=1. The state is sticky until reset; err_cause is frozen.
//  - rsp_valid outside WAIT is ignored, with no state change.
//  - Reset asserted mid-transaction returns to IDLE immediately. The memory side must drop
//    any outstanding response.
//  - req_addr is always fetch_pc. It is never updated while req_valid=1 and req_ready=0.
// STRUCTURE
//  - Shared package ifu_pkg: state enum (IDLE/REQ/WAIT/HOLD/ERR), err_cause localparams
//    ERR_NONE/ERR_BUS/ERR_TIMEOUT/ERR_MISALIGN, and RESET_PC default constant.
//  - Single module with no sub-module. The FSM, timeout counter and retire counter are
//    inline always blocks with async reset.
// TESTING
//  1. Release reset; memory has req_ready=1 and responds next cycle with 32'h00000413 ->
//     req_addr=8000_0000, then inst_valid with inst=00000413 and inst_pc=8000_0000.
//  2. Hold req_ready=0 for 5 cycles -> req_valid stays 1 and req_addr is stable; WAIT is
//     entered only after req_ready rises.
//  3. HOLD with inst_ready=0 for 4 cycles, then inst_ready=1 with npc=8000_0010 ->
//     inst is stable while held; next req_addr=8000_0010; inst_count=1.
//  4. rsp_valid=1 with rsp_err=1 -> err=1, err_cause=1, req_valid and inst_valid stay 0
//     until reset; a later reset clears err.
//  5. TIMEOUT=4 with no response -> err_cause=2 after 4 WAIT cycles. A response on the 4th
//     WAIT cycle is accepted instead, with no error.
//  6. Consume with npc=8000_0006 -> err_cause=3 and no new request; pulse rst low mid-WAIT
//     -> outputs return to reset values asynchronously.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared constants for the instruction fetch unit: FSM state codes, fault causes, widths.
package ifu_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned STATE_W    = 3;
    localparam int unsigned CAUSE_W    = 2;
    localparam int unsigned WAIT_CNT_W = 16;

    localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
    localparam logic [STATE_W-1:0] ST_REQ  = 3'd1;
    localparam logic [STATE_W-1:0] ST_WAIT = 3'd2;
    localparam logic [STATE_W-1:0] ST_HOLD = 3'd3;
    localparam logic [STATE_W-1:0] ST_ERR  = 3'd4;

    localparam logic [CAUSE_W-1:0] ERR_NONE     = 2'd0;
    localparam logic [CAUSE_W-1:0] ERR_BUS      = 2'd1;
    localparam logic [CAUSE_W-1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [CAUSE_W-1:0] ERR_MISALIGN = 2'd3;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

    // A next PC is only usable if it is word aligned.
    function automatic logic is_misaligned(input logic [XLEN-1:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Memory request/response and core-facing instruction signals of the fetch unit.
interface inst_fetch_unit_if;
    import ifu_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic [XLEN-1:0]      req_addr;
    logic                 rsp_valid;
    logic [XLEN-1:0]      rsp_data;
    logic                 rsp_err;
    logic                 inst_valid;
    logic                 inst_ready;
    logic [XLEN-1:0]      inst;
    logic [XLEN-1:0]      inst_pc;
    logic [XLEN-1:0]      npc;
    logic                 err;
    logic [CAUSE_W-1:0]   err_cause;
    logic [XLEN-1:0]      inst_count;

    // Fetch unit side.
    modport master (
        output req_valid, req_addr, inst_valid, inst, inst_pc, err, err_cause, inst_count,
        input  req_ready, rsp_valid, rsp_data, rsp_err, inst_ready, npc
    );

    // Memory and core side.
    modport slave (
        input  req_valid, req_addr, inst_valid, inst, inst_pc, err, err_cause, inst_count,
        output req_ready, rsp_valid, rsp_data, rsp_err, inst_ready, npc
    );

endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: one outstanding memory read, one instruction presented to the core,
// next fetch address taken from the core's dnpc. Faults are sticky until reset.
module inst_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [XLEN-1:0]       RESET_PC = RESET_PC_DEFAULT,
    parameter logic [WAIT_CNT_W-1:0] TIMEOUT  = 16'd1024
) (
    input  logic               clk,
    input  logic               rst,
    inst_fetch_unit_if.master  bus
);

    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_LAST = TIMEOUT - WAIT_CNT_W'(1);
    localparam logic                  TIMEOUT_EN   = (TIMEOUT != '0);

    logic [STATE_W-1:0]    state_q,      state_d;
    logic [XLEN-1:0]       fetch_pc_q,   fetch_pc_d;
    logic [XLEN-1:0]       inst_q,       inst_d;
    logic [XLEN-1:0]       inst_pc_q,    inst_pc_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q,   wait_cnt_d;
    logic [CAUSE_W-1:0]    err_cause_q,  err_cause_d;
    logic [XLEN-1:0]       inst_count_q, inst_count_d;
    logic                  req_valid_q,  req_valid_d;
    logic                  inst_valid_q, inst_valid_d;
    logic                  err_q,        err_d;

    logic rsp_ok;
    logic rsp_bad;
    logic retire;
    logic timed_out;

    always_comb begin
        rsp_ok    = bus.rsp_valid && !bus.rsp_err;
        rsp_bad   = bus.rsp_valid &&  bus.rsp_err;
        retire    = (state_q == ST_HOLD) && bus.inst_ready;
        timed_out = TIMEOUT_EN && (wait_cnt_q == TIMEOUT_LAST);
    end

    // Next-state and datapath updates; responses outside WAIT fall through untouched.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        wait_cnt_d   = wait_cnt_q;
        err_cause_d  = err_cause_q;
        inst_count_d = inst_count_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (bus.req_ready) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = '0;
                end
            end
            ST_WAIT: begin
                // Bus error beats data; a response in the last allowed cycle beats the timeout.
                if (rsp_bad) begin
                    state_d     = ST_ERR;
                    err_cause_d = ERR_BUS;
                end else if (rsp_ok) begin
                    state_d   = ST_HOLD;
                    inst_d    = bus.rsp_data;
                    inst_pc_d = fetch_pc_q;
                end else if (timed_out) begin
                    state_d     = ST_ERR;
                    err_cause_d = ERR_TIMEOUT;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (retire) begin
                    inst_count_d = inst_count_q + XLEN'(1);
                    if (is_misaligned(bus.npc)) begin
                        state_d     = ST_ERR;
                        err_cause_d = ERR_MISALIGN;
                    end else begin
                        state_d    = ST_REQ;
                        fetch_pc_d = bus.npc;
                    end
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Valid/flag outputs are registered from the next state so they line up with state_q.
    always_comb begin
        req_valid_d  = (state_d == ST_REQ);
        inst_valid_d = (state_d == ST_HOLD);
        err_d        = (state_d == ST_ERR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            fetch_pc_q   <= RESET_PC;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            err_cause_q  <= ERR_NONE;
            req_valid_q  <= 1'b0;
            inst_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            err_cause_q  <= err_cause_d;
            req_valid_q  <= req_valid_d;
            inst_valid_q <= inst_valid_d;
            err_q        <= err_d;
        end
    end

    // Response timeout counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Retired instruction counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_count_q <= '0;
        end else begin
            inst_count_q <= inst_count_d;
        end
    end

    assign bus.req_valid  = req_valid_q;
    assign bus.req_addr   = fetch_pc_q;
    assign bus.inst_valid = inst_valid_q;
    assign bus.inst       = inst_q;
    assign bus.inst_pc    = inst_pc_q;
    assign bus.err        = err_q;
    assign bus.err_cause  = err_cause_q;
    assign bus.inst_count = inst_count_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios plus a randomized fetch stream
// checked against a transaction-level model of PC flow, memory contents and retire count.
module tb_inst_fetch_unit;
    import ifu_pkg::*;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    inst_fetch_unit_if ifc();

    inst_fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT(16'd4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h0000_0413;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifc.req_ready  = 1'b0;
        ifc.rsp_valid  = 1'b0;
        ifc.rsp_data   = '0;
        ifc.rsp_err    = 1'b0;
        ifc.inst_ready = 1'b0;
        ifc.npc        = '0;
    endtask

    // Leaves the DUT in REQ with the first request presented.
    task automatic apply_reset();
        rst = 1'b0;
        clear_inputs();
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    // Request handshake followed by a one-cycle memory response; ends in HOLD.
    task automatic fetch_quick(input logic [31:0] data);
        ifc.req_ready = 1'b1;
        step();
        ifc.req_ready = 1'b0;
        ifc.rsp_valid = 1'b1;
        ifc.rsp_data  = data;
        step();
        ifc.rsp_valid = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if ({ifc.req_valid, ifc.inst_valid, ifc.err, ifc.err_cause} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 00000", {ifc.req_valid, ifc.inst_valid, ifc.err, ifc.err_cause});
        end
        vectors++;
        if ({ifc.inst, ifc.inst_pc, ifc.inst_count} !== 96'h0) begin
            miscompares++;
            $display("FAIL reset_data: got inst=%h pc=%h cnt=%h want zeros", ifc.inst, ifc.inst_pc, ifc.inst_count);
        end
        vectors++;
        if (ifc.req_addr !== RST_PC) begin
            miscompares++;
            $display("FAIL reset_addr: got %h want %h", ifc.req_addr, RST_PC);
        end
        step();
        step();
        rst = 1'b1;
        step();
        vectors++;
        if ({ifc.req_valid, ifc.req_addr} !== {1'b1, RST_PC}) begin
            miscompares++;
            $display("FAIL reset_first_req: got v=%b a=%h want v=1 a=%h", ifc.req_valid, ifc.req_addr, RST_PC);
        end
    endtask

    task automatic test_basic_fetch();
        apply_reset();
        ifc.req_ready = 1'b1;
        step();
        ifc.req_ready = 1'b0;
        vectors++;
        if ({ifc.req_valid, ifc.inst_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL basic_wait_valids: got %b want 00", {ifc.req_valid, ifc.inst_valid});
        end
        ifc.rsp_valid = 1'b1;
        ifc.rsp_data  = 32'h0000_0413;
        step();
        ifc.rsp_valid = 1'b0;
        vectors++;
        if ({ifc.inst_valid, ifc.inst, ifc.inst_pc} !== {1'b1, 32'h0000_0413, RST_PC}) begin
            miscompares++;
            $display("FAIL basic_inst: got v=%b i=%h pc=%h want v=1 i=00000413 pc=%h", ifc.inst_valid, ifc.inst, ifc.inst_pc, RST_PC);
        end
    endtask

    task automatic test_req_backpressure();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({ifc.req_valid, ifc.req_addr} !== {1'b1, RST_PC}) begin
                miscompares++;
                $display("FAIL stall_req cycle %0d: got v=%b a=%h want v=1 a=%h", i, ifc.req_valid, ifc.req_addr, RST_PC);
            end
            // A stray response while requesting must be ignored.
            ifc.rsp_valid = (i == 2);
            ifc.rsp_data  = 32'hDEAD_BEEF;
            step();
            ifc.rsp_valid = 1'b0;
        end
        vectors++;
        if (ifc.inst_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_stray_rsp: got inst_valid=%b want 0", ifc.inst_valid);
        end
        ifc.req_ready = 1'b1;
        step();
        ifc.req_ready = 1'b0;
        vectors++;
        if (ifc.req_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_enter_wait: got req_valid=%b want 0", ifc.req_valid);
        end
    endtask

    task automatic test_hold_stall();
        apply_reset();
        fetch_quick(32'h1234_5678);
        for (int i = 0; i < 4; i++) begin
            ifc.rsp_valid = 1'b1;
            ifc.rsp_data  = 32'hCAFE_0000 + 32'(i);
            step();
            ifc.rsp_valid = 1'b0;
            vectors++;
            if ({ifc.inst_valid, ifc.inst, ifc.inst_pc} !== {1'b1, 32'h1234_5678, RST_PC}) begin
                miscompares++;
                $display("FAIL hold_stable cycle %0d: got v=%b i=%h pc=%h", i, ifc.inst_valid, ifc.inst, ifc.inst_pc);
            end
        end
        ifc.inst_ready = 1'b1;
        ifc.npc        = 32'h8000_0010;
        step();
        ifc.inst_ready = 1'b0;
        vectors++;
        if ({ifc.inst_valid, ifc.req_valid, ifc.req_addr, ifc.inst_count} !== {2'b01, 32'h8000_0010, 32'd1}) begin
            miscompares++;
            $display("FAIL hold_consume: got iv=%b rv=%b a=%h cnt=%0d want iv=0 rv=1 a=80000010 cnt=1", ifc.inst_valid, ifc.req_valid, ifc.req_addr, ifc.inst_count);
        end
    endtask

    task automatic test_bus_error();
        apply_reset();
        ifc.req_ready = 1'b1;
        step();
        ifc.req_ready = 1'b0;
        ifc.rsp_valid = 1'b1;
        ifc.rsp_err   = 1'b1;
        ifc.rsp_data  = 32'h0000_0013;
        step();
        ifc.rsp_valid = 1'b0;
        ifc.rsp_err   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if ({ifc.err, ifc.err_cause, ifc.req_valid, ifc.inst_valid} !== {1'b1, ERR_BUS, 2'b00}) begin
                miscompares++;
                $display("FAIL bus_err_sticky cycle %0d: got err=%b cause=%0d rv=%b iv=%b", i, ifc.err, ifc.err_cause, ifc.req_valid, ifc.inst_valid);
            end
            ifc.req_ready = 1'b1;
            ifc.rsp_valid = 1'($urandom_range(1, 0));
            step();
        end
        clear_inputs();
        apply_reset();
        vectors++;
        if ({ifc.err, ifc.err_cause, ifc.req_valid} !== 4'b0001) begin
            miscompares++;
            $display("FAIL bus_err_cleared: got err=%b cause=%0d rv=%b want 0 0 1", ifc.err, ifc.err_cause, ifc.req_valid);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        ifc.req_ready = 1'b1;
        step();
        ifc.req_ready = 1'b0;
        step();
        step();
        step();
        vectors++;
        if (ifc.err !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_early: got err=%b want 0 after 3 wait cycles", ifc.err);
        end
        step();
        vectors++;
        if ({ifc.err, ifc.err_cause} !== {1'b1, ERR_TIMEOUT}) begin
            miscompares++;
            $display("FAIL timeout_fire: got err=%b cause=%0d want 1 2", ifc.err, ifc.err_cause);
        end
        // Response arriving in the last allowed WAIT cycle wins.
        apply_reset();
        ifc.req_ready = 1'b1;
        step();
        ifc.req_ready = 1'b0;
        step();
        step();
        step();
        ifc.rsp_valid = 1'b1;
        ifc.rsp_data  = 32'h00A0_0093;
        step();
        ifc.rsp_valid = 1'b0;
        vectors++;
        if ({ifc.err, ifc.inst_valid, ifc.inst} !== {2'b01, 32'h00A0_0093}) begin
            miscompares++;
            $display("FAIL timeout_edge_accept: got err=%b iv=%b i=%h want 0 1 00a00093", ifc.err, ifc.inst_valid, ifc.inst);
        end
    endtask

    task automatic test_misalign_and_async_reset();
        apply_reset();
        fetch_quick(32'h0000_0413);
        ifc.inst_ready = 1'b1;
        ifc.npc        = 32'h8000_0006;
        step();
        ifc.inst_ready = 1'b0;
        ifc.req_ready  = 1'b1;
        step();
        step();
        vectors++;
        if ({ifc.err, ifc.err_cause, ifc.req_valid, ifc.req_addr, ifc.inst_count} !== {1'b1, ERR_MISALIGN, 1'b0, RST_PC, 32'd1}) begin
            miscompares++;
            $display("FAIL misalign: got err=%b cause=%0d rv=%b a=%h cnt=%0d want 1 3 0 %h 1", ifc.err, ifc.err_cause, ifc.req_valid, ifc.req_addr, ifc.inst_count, RST_PC);
        end
        ifc.req_ready = 1'b0;
        apply_reset();
        fetch_quick(32'h0000_0517);
        ifc.inst_ready = 1'b1;
        ifc.npc        = 32'h8000_0100;
        step();
        ifc.inst_ready = 1'b0;
        ifc.req_ready  = 1'b1;
        step();
        ifc.req_ready = 1'b0;
        step();
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if ({ifc.req_valid, ifc.inst_valid, ifc.err, ifc.req_addr, ifc.inst, ifc.inst_pc, ifc.inst_count} !== {3'b000, RST_PC, 96'h0}) begin
            miscompares++;
            $display("FAIL async_reset: got rv=%b iv=%b err=%b a=%h i=%h pc=%h cnt=%0d", ifc.req_valid, ifc.inst_valid, ifc.err, ifc.req_addr, ifc.inst, ifc.inst_pc, ifc.inst_count);
        end
        step();
        rst = 1'b1;
    endtask

    task automatic test_random_stream();
        logic [31:0] exp_pc;
        logic [31:0] exp_count;
        logic [31:0] npc_v;
        int          rs;
        int          ws;
        int          hs;
        apply_reset();
        exp_pc    = RST_PC;
        exp_count = '0;
        for (int n = 0; n < 40; n++) begin
            rs = int'($urandom_range(3, 0));
            ws = int'($urandom_range(3, 0));
            hs = int'($urandom_range(3, 0));
            for (int k = 0; k < rs; k++) begin
                step();
            end
            vectors++;
            if ({ifc.req_valid, ifc.req_addr} !== {1'b1, exp_pc}) begin
                miscompares++;
                $display("FAIL rand_req #%0d: got v=%b a=%h want v=1 a=%h", n, ifc.req_valid, ifc.req_addr, exp_pc);
            end
            ifc.req_ready = 1'b1;
            step();
            ifc.req_ready = 1'b0;
            for (int k = 0; k < ws; k++) begin
                step();
            end
            ifc.rsp_valid = 1'b1;
            ifc.rsp_data  = mem_word(ifc.req_addr);
            step();
            ifc.rsp_valid = 1'b0;
            for (int k = 0; k < hs; k++) begin
                step();
            end
            vectors++;
            if ({ifc.inst_valid, ifc.inst, ifc.inst_pc} !== {1'b1, mem_word(exp_pc), exp_pc}) begin
                miscompares++;
                $display("FAIL rand_inst #%0d: got v=%b i=%h pc=%h want v=1 i=%h pc=%h", n, ifc.inst_valid, ifc.inst, ifc.inst_pc, mem_word(exp_pc), exp_pc);
            end
            npc_v          = $urandom() & 32'hFFFF_FFFC;
            ifc.npc        = npc_v;
            ifc.inst_ready = 1'b1;
            step();
            ifc.inst_ready = 1'b0;
            exp_pc    = npc_v;
            exp_count = exp_count + 32'd1;
            vectors++;
            if ({ifc.err, ifc.inst_count} !== {1'b0, exp_count}) begin
                miscompares++;
                $display("FAIL rand_retire #%0d: got err=%b cnt=%0d want err=0 cnt=%0d", n, ifc.err, ifc.inst_count, exp_count);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        clear_inputs();
        test_reset();
        test_basic_fetch();
        test_req_backpressure();
        test_hold_stall();
        test_bus_error();
        test_timeout();
        test_misalign_and_async_reset();
        test_random_stream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
